// File: rtl/pmem_if.sv
// One 256-bit-line memory port. A request (read or write) is held high with a
// stable address/wdata until resp pulses for one cycle; rdata is valid only while resp is high.
interface pmem_if;
   logic         read;
   logic         write;
   logic [31:0]  address;
   logic [255:0] wdata;
   logic         resp;
   logic [255:0] rdata;

   modport master   (output read, write, address, wdata, input resp, rdata);
   modport slave    (input read, write, address, wdata, output resp, rdata);
   // Read-only requester view (icache never writes back)
   modport slave_rd (input read, address, output resp, rdata);
endinterface

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory port between icache and dcache: one transfer at a
// time, round-robin on ties, latched request drives the port, response routed to the winner.
module pmem_arbiter (
   input  logic        clk,
   input  logic        rst,
   pmem_if.slave_rd    icache,
   pmem_if.slave       dcache,
   pmem_if.master      mem,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

   localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

   state_t       state, next_state;
   logic         last_grant_d;
   logic         write_q;
   logic [31:0]  addr_q;
   logic [255:0] wdata_q;
   logic         i_req, d_req;
   logic         grant_i, grant_d;
   logic         serving;

   assign i_req = icache.read;
   assign d_req = dcache.read | dcache.write;

   always_comb begin
      next_state = state;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      case (state)
         IDLE: begin
            // On a tie, the cache that was not served last wins
            if (i_req && (!d_req || last_grant_d)) begin
               grant_i    = 1'b1;
               next_state = SERVE_I;
            end else if (d_req) begin
               grant_d    = 1'b1;
               next_state = SERVE_D;
            end
         end
         SERVE_I, SERVE_D: begin
            if (mem.resp) next_state = DONE;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         last_grant_d <= 1'b1;
         write_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
      end else begin
         state <= next_state;
         if (grant_i) begin
            addr_q       <= icache.address & LINE_MASK;
            write_q      <= 1'b0;
            last_grant_d <= 1'b0;
         end else if (grant_d) begin
            // A simultaneous read+write from the dcache is served as the write
            addr_q       <= dcache.address & LINE_MASK;
            wdata_q      <= dcache.wdata;
            write_q      <= dcache.write;
            last_grant_d <= 1'b1;
         end
      end
   end

   assign serving     = (state == SERVE_I) || (state == SERVE_D);
   assign mem.read    = serving & ~write_q;
   assign mem.write   = serving & write_q;
   assign mem.address = addr_q;
   assign mem.wdata   = wdata_q;

   assign icache.resp  = mem.resp & (state == SERVE_I);
   assign dcache.resp  = mem.resp & (state == SERVE_D);
   assign icache.rdata = mem.rdata;
   assign dcache.rdata = mem.rdata;

   assign dbg_state = state;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: randomized requests and memory latencies
// checked against a tie-break/latency model of the arbiter's contract.
module tb_pmem_arbiter;

  localparam logic [1:0] DBG_IDLE = 2'd0;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  pmem_if icache_bus ();
  pmem_if dcache_bus ();
  pmem_if mem_bus ();

  pmem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .icache    (icache_bus),
    .dcache    (dcache_bus),
    .mem       (mem_bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit last_d = 1'b1;   // model: which cache was served last (reset: dcache)
  int last_wait;
  bit got_d;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Model of the grant rule: ties go to the cache not served last
  function automatic bit pick_d(bit i_req, bit d_req);
    if (i_req && d_req) return !last_d;
    return d_req;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    icache_bus.read = 1'b0; icache_bus.write = 1'b0;
    icache_bus.address = '0; icache_bus.wdata = '0;
    dcache_bus.read = 1'b0; dcache_bus.write = 1'b0;
    dcache_bus.address = '0; dcache_bus.wdata = '0;
    mem_bus.resp = 1'b0; mem_bus.rdata = '0;
    step();
    step();
    rst = 1'b0;
    last_d = 1'b1;
  endtask

  // Waits for a strobe, answers after lat strobe cycles, checks routing, then the DONE gap
  task automatic expect_transfer(input bit exp_d, input bit exp_wr, input logic [31:0] req_addr,
                                 input logic [255:0] exp_wdata, input int lat,
                                 input logic [255:0] line, input string name);
    int waited = 0;
    logic [31:0] exp_addr = req_addr & 32'hFFFF_FFE0;
    while (!(mem_bus.read | mem_bus.write) && waited < 20) begin
      step();
      waited++;
    end
    last_wait = waited;
    checks++;
    if (!(mem_bus.read | mem_bus.write)) begin
      $display("FAIL %s strobe: no strobe within 20 cycles, required one", name);
      return;
    end
    passes++;
    checks++;
    if (mem_bus.address !== exp_addr)
      $display("FAIL %s address: got %h, required %h", name, mem_bus.address, exp_addr);
    else passes++;
    if (exp_wr) begin
      checks++;
      if (mem_bus.wdata !== exp_wdata)
        $display("FAIL %s wdata: got %h, required %h", name, mem_bus.wdata, exp_wdata);
      else passes++;
    end
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) step();
      checks++;
      if ({mem_bus.read, mem_bus.write} !== {!exp_wr, exp_wr})
        $display("FAIL %s strobes cycle %0d: got %b, required %b", name, k,
                 {mem_bus.read, mem_bus.write}, {!exp_wr, exp_wr});
      else passes++;
    end
    mem_bus.rdata = line;
    mem_bus.resp = 1'b1;
    #1;
    got_d = dcache_bus.resp;
    checks++;
    if ({icache_bus.resp, dcache_bus.resp} !== {!exp_d, exp_d})
      $display("FAIL %s resp routing: got i/d=%b, required %b", name,
               {icache_bus.resp, dcache_bus.resp}, {!exp_d, exp_d});
    else passes++;
    checks++;
    if ((exp_d ? dcache_bus.rdata : icache_bus.rdata) !== line)
      $display("FAIL %s rdata: got %h, required %h", name,
               exp_d ? dcache_bus.rdata : icache_bus.rdata, line);
    else passes++;
    step();
    mem_bus.resp = 1'b0;
    checks++;
    if ({mem_bus.read, mem_bus.write} !== 2'b00)
      $display("FAIL %s done gap: strobes %b, required 00", name, {mem_bus.read, mem_bus.write});
    else passes++;
    last_d = exp_d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    icache_bus.read = 1'b1; icache_bus.address = 32'hFFFF_FFFF;
    icache_bus.write = 1'b0; icache_bus.wdata = '0;
    dcache_bus.read = 1'b0; dcache_bus.write = 1'b1;
    dcache_bus.address = 32'hFFFF_FFFF; dcache_bus.wdata = '1;
    mem_bus.resp = 1'b1; mem_bus.rdata = '1;
    step();
    step();
    checks++;
    if ({mem_bus.read, mem_bus.write, icache_bus.resp, dcache_bus.resp} !== 4'b0000)
      $display("FAIL reset outputs: got %b, required 0000",
               {mem_bus.read, mem_bus.write, icache_bus.resp, dcache_bus.resp});
    else passes++;
    checks++;
    if (mem_bus.address !== 32'h0 || mem_bus.wdata !== 256'h0)
      $display("FAIL reset port: address %h wdata %h, required zeros", mem_bus.address, mem_bus.wdata);
    else passes++;
    checks++;
    if (dbg_state !== DBG_IDLE)
      $display("FAIL reset state: got %0d, required %0d", dbg_state, DBG_IDLE);
    else passes++;
    do_reset();
  endtask

  task automatic test_icache_miss();
    icache_bus.read = 1'b1;
    icache_bus.address = 32'h0000_1234;
    expect_transfer(1'b0, 1'b0, 32'h0000_1234, '0, 4, {32{8'hAA}}, "icache_miss");
    checks++;
    if (last_wait != 1)
      $display("FAIL icache_miss latency: strobe after %0d cycles, required 1", last_wait);
    else passes++;
    icache_bus.read = 1'b0;
    step();
  endtask

  task automatic test_dcache_wb_fill();
    logic [255:0] wd = {32{8'h55}};
    dcache_bus.write = 1'b1;
    dcache_bus.address = 32'h8000_0040;
    dcache_bus.wdata = wd;
    expect_transfer(1'b1, 1'b1, 32'h8000_0040, wd, $urandom_range(1, 5), rand_line(), "d_writeback");
    dcache_bus.write = 1'b0;
    dcache_bus.read = 1'b1;
    dcache_bus.address = 32'h8000_1040;
    expect_transfer(1'b1, 1'b0, 32'h8000_1040, '0, $urandom_range(1, 5), rand_line(), "d_fill");
    checks++;
    if (last_wait != 2)
      $display("FAIL d_fill gap: strobe %0d cycles after DONE, required 2", last_wait);
    else passes++;
    dcache_bus.read = 1'b0;
    step();
  endtask

  task automatic test_tie_after_reset();
    logic [31:0] ia, da;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      ia = $urandom; da = $urandom;
      icache_bus.read = 1'b1; icache_bus.address = ia;
      dcache_bus.read = 1'b1; dcache_bus.address = da;
      expect_transfer(pick_d(1'b1, 1'b1), 1'b0, pick_d(1'b1, 1'b1) ? da : ia, '0,
                      $urandom_range(1, 4), rand_line(), "tie_first");
      checks++;
      if (got_d !== 1'b0)
        $display("FAIL tie round %0d: dcache served first, required icache", r);
      else passes++;
      icache_bus.read = 1'b0;
      expect_transfer(1'b1, 1'b0, da, '0, $urandom_range(1, 4), rand_line(), "tie_second");
      dcache_bus.read = 1'b0;
      step();
    end
  endtask

  task automatic test_contention();
    logic [31:0]  ia, da;
    logic [255:0] dw;
    bit           dwr, exp_d, prev_d;
    int           n_i = 0, n_d = 0;
    ia = $urandom; da = $urandom; dw = rand_line(); dwr = 1'($urandom_range(0, 1));
    icache_bus.read = 1'b1; icache_bus.address = ia;
    dcache_bus.read = !dwr; dcache_bus.write = dwr;
    dcache_bus.address = da; dcache_bus.wdata = dw;
    for (int n = 0; n < 10; n++) begin
      exp_d = pick_d(1'b1, 1'b1);
      expect_transfer(exp_d, exp_d & dwr, exp_d ? da : ia, dw, $urandom_range(1, 5),
                      rand_line(), "contention");
      if (n > 0) begin
        checks++;
        if (got_d === prev_d)
          $display("FAIL contention alternation at %0d: same cache %0d granted twice", n, got_d);
        else passes++;
      end
      prev_d = got_d;
      if (got_d) n_d++; else n_i++;
      if (exp_d) begin
        da = $urandom; dw = rand_line(); dwr = 1'($urandom_range(0, 1));
        dcache_bus.read = !dwr; dcache_bus.write = dwr;
        dcache_bus.address = da; dcache_bus.wdata = dw;
      end else begin
        ia = $urandom;
        icache_bus.address = ia;
      end
    end
    checks++;
    if (n_i != 5 || n_d != 5)
      $display("FAIL contention share: icache %0d dcache %0d, required 5 and 5", n_i, n_d);
    else passes++;
    icache_bus.read = 1'b0;
    dcache_bus.read = 1'b0;
    dcache_bus.write = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    int waited = 0;
    logic [31:0] ia;
    dcache_bus.write = 1'b1;
    dcache_bus.address = $urandom;
    dcache_bus.wdata = rand_line();
    while (!mem_bus.write && waited < 20) begin
      step();
      waited++;
    end
    checks++;
    if (!mem_bus.write)
      $display("FAIL reset_mid strobe: no strobe within 20 cycles, required mem_write");
    else passes++;
    step();
    #2;
    mem_bus.resp = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_bus.read, mem_bus.write, dcache_bus.resp, icache_bus.resp} !== 4'b0000)
      $display("FAIL reset_mid async: strobes/resps %b, required 0000",
               {mem_bus.read, mem_bus.write, dcache_bus.resp, icache_bus.resp});
    else passes++;
    step();
    mem_bus.resp = 1'b0;
    dcache_bus.write = 1'b0;
    step();
    rst = 1'b0;
    last_d = 1'b1;
    ia = $urandom;
    icache_bus.read = 1'b1;
    icache_bus.address = ia;
    expect_transfer(1'b0, 1'b0, ia, '0, $urandom_range(1, 5), rand_line(), "after_reset");
    checks++;
    if (last_wait != 1)
      $display("FAIL after_reset latency: strobe after %0d cycles, required 1", last_wait);
    else passes++;
    icache_bus.read = 1'b0;
    step();
  endtask

  task automatic test_spurious();
    step();
    mem_bus.resp = 1'b1;
    mem_bus.rdata = rand_line();
    #1;
    checks++;
    if ({icache_bus.resp, dcache_bus.resp} !== 2'b00)
      $display("FAIL spurious resp: got i/d=%b, required 00", {icache_bus.resp, dcache_bus.resp});
    else passes++;
    step();
    mem_bus.resp = 1'b0;
    checks++;
    if (dbg_state !== DBG_IDLE || {mem_bus.read, mem_bus.write} !== 2'b00)
      $display("FAIL spurious state: state %0d strobes %b, required %0d and 00",
               dbg_state, {mem_bus.read, mem_bus.write}, DBG_IDLE);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_icache_miss();
    test_dcache_wb_fill();
    test_tie_after_reset();
    test_contention();
    test_reset_mid();
    test_spurious();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
